// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
package rr_arbiter_4_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int DEF_MAX_HOLD = 8;

endpackage : rr_arbiter_4_pkg

// File: rtl/rr_arbiter_4_pick.sv
// Combinational cyclic priority pick: first asserted candidate at or above ptr_i, wrapping mod 4.
module rr_pick_4 (
    input  logic [3:0] cand_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] pick_o,
    output logic [1:0] idx_o
);

    // rot[k] is the candidate k positions above the pointer.
    logic [1:0] idx_k [4];
    logic [3:0] rot;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign idx_k[gi] = ptr_i + 2'(gi);
        assign rot[gi]   = cand_i[idx_k[gi]];
    end

    logic found;

    always_comb begin
        found  = 1'b0;
        idx_o  = '0;
        pick_o = '0;
        for (int k = 0; k < 4; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                idx_o = idx_k[k];
            end
        end
        if (found) begin
            pick_o = 4'b0001 << idx_o;
        end
    end

endmodule : rr_pick_4

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters with registered one-hot grant and optional hold limit.
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid
);

    localparam bit                HOLD_EN     = (MAX_HOLD > 0);
    localparam int                HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_LAST_I);

    arb_state_e       state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       gnt_id_q, gnt_id_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic [3:0] others_vec;
    logic       owner_req;
    logic       others_pending;
    logic       at_limit;

    logic [3:0] pick_all, pick_msk;
    logic [1:0] idx_all, idx_msk;

    // While idle gnt_q is zero, so others_vec is simply req.
    assign others_vec     = req & ~gnt_q;
    assign owner_req      = |(req & gnt_q);
    assign others_pending = |others_vec;
    assign at_limit       = HOLD_EN && (hold_q == HOLD_LAST);

    rr_pick_4 u_pick_all (
        .cand_i (req),
        .ptr_i  (ptr_q),
        .pick_o (pick_all),
        .idx_o  (idx_all)
    );

    rr_pick_4 u_pick_msk (
        .cand_i (others_vec),
        .ptr_i  (ptr_q),
        .pick_o (pick_msk),
        .idx_o  (idx_msk)
    );

    logic new_grant;
    logic use_mask;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        new_grant = 1'b0;
        use_mask  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    new_grant = 1'b1;
                end
            end
            ST_BUSY: begin
                if (!owner_req) begin
                    if (others_pending) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                        hold_d   = '0;
                    end
                end else if (at_limit && others_pending) begin
                    new_grant = 1'b1;
                    use_mask  = 1'b1;
                end else if (HOLD_EN && (hold_q != HOLD_LAST)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                hold_d   = '0;
            end
        endcase

        // Every fresh grant restarts the hold count and moves the pointer past the winner.
        if (new_grant) begin
            state_d  = ST_BUSY;
            gnt_d    = use_mask ? pick_msk : pick_all;
            gnt_id_d = use_mask ? idx_msk  : idx_all;
            ptr_d    = gnt_id_d + 2'd1;
            hold_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = (state_q == ST_BUSY);

endmodule : rr_arbiter_4

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 with MAX_HOLD = 8.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    int total;
    int bad;

    rr_arbiter_4 #(
        .MAX_HOLD (8),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_gnt);
        logic [1:0] e_id;
        logic       e_vld;
        e_id  = 2'd0;
        e_vld = |e_gnt;
        for (int i = 0; i < 4; i++) begin
            if (e_gnt[i]) e_id = 2'(i);
        end
        chk({tag, ".gnt"}, {4'b0, gnt}, {4'b0, e_gnt});
        chk({tag, ".id"},  {6'b0, gnt_id}, {6'b0, e_id});
        chk({tag, ".vld"}, {7'b0, gnt_valid}, {7'b0, e_vld});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded run time in case the clock or the flow stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 4'b1111;

        // Reset with all requesting
        step();
        step();
        chk_out("rst_hold", 4'b0000);
        rst_n = 1'b1;
        chk_out("rst_rel", 4'b0000);
        step();
        chk_out("rst_first", 4'b0001);

        // Rotation: each owner drops for one cycle after its grant
        req = 4'b1110; step(); chk_out("rot1", 4'b0010);
        req = 4'b1101; step(); chk_out("rot2", 4'b0100);
        req = 4'b1011; step(); chk_out("rot3", 4'b1000);
        req = 4'b0111; step(); chk_out("rot0", 4'b0001);

        // Hold limit from a clean reset with req=0101
        rst_n = 1'b0;
        req   = 4'b0101;
        step();
        chk_out("hold_rst", 4'b0000);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("hold_r0", {4'b0, gnt}, 8'h01);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            chk("hold_r2", {4'b0, gnt}, 8'h04);
        end
        step();
        chk_out("hold_back0", 4'b0001);

        // Sole requester is never preempted
        req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("sole_r3", {4'b0, gnt}, 8'h08);
        end
        chk_out("sole_end", 4'b1000);

        // Release to idle, then pointer-driven pick
        req = 4'b0010; step(); chk_out("idle_g1", 4'b0010);
        req = 4'b0000; step(); chk_out("idle_off", 4'b0000);
        step();                chk_out("idle_stay", 4'b0000);
        req = 4'b0011; step(); chk_out("idle_ptr2", 4'b0001);

        // Async reset mid-grant
        req = 4'b0100; step(); chk_out("ar_g2", 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("ar_drop", 4'b0000);
        step();
        chk_out("ar_inrst", 4'b0000);
        rst_n = 1'b1;
        chk_out("ar_rel", 4'b0000);
        step();
        chk_out("ar_regrant", 4'b0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rr_arbiter_4
